// File: rtl/spi_xfer_queue_if.sv
// Command, response and spi_master-facing signals of the SPI transfer queue.
interface spi_xfer_queue_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_data;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic                  spi_start;
  logic [DATA_WIDTH-1:0] spi_tx_data;
  logic                  spi_busy;
  logic [DATA_WIDTH-1:0] spi_rx_data;

  // Queue side: accepts commands, offers responses, drives spi_master.
  modport slave (
    input  cmd_valid, cmd_data, rsp_ready, spi_busy, spi_rx_data,
    output cmd_ready, rsp_valid, rsp_data, spi_start, spi_tx_data
  );

  // Controller / spi_master side.
  modport master (
    output cmd_valid, cmd_data, rsp_ready, spi_busy, spi_rx_data,
    input  cmd_ready, rsp_valid, rsp_data, spi_start, spi_tx_data
  );

endinterface

// File: rtl/spi_xfer_queue.sv
// Command/response queue in front of spi_master: one bus transaction per queued word,
// received words returned in command order through a response FIFO.
module spi_xfer_queue #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_TICKS  = 8,
  parameter int unsigned BUSY_TMO   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  spi_xfer_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0] cmd_level,
  output logic [$clog2(DEPTH):0] rsp_level,
  output logic                   idle,
  output logic                   err_tmo
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned CNT_MAX = (GAP_TICKS > BUSY_TMO) ? GAP_TICKS : BUSY_TMO;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_CAPTURE   = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic                  drop_q;
  logic [DATA_WIDTH-1:0] tx_q;

  logic [DATA_WIDTH-1:0] cmd_mem [DEPTH];
  logic [AW-1:0]         cmd_wptr, cmd_rptr;
  logic [LW-1:0]         cmd_cnt;
  logic [DATA_WIDTH-1:0] rsp_mem [DEPTH];
  logic [AW-1:0]         rsp_wptr, rsp_rptr;
  logic [LW-1:0]         rsp_cnt;

  logic cmd_push, cmd_pop, rsp_push, rsp_pop;
  logic start_ok, tmo_hit, gap_done;
  state_t post_xfer;

  // Handshakes and FSM guards. The IDLE guard only needs rsp occupancy: nothing is in flight in IDLE.
  always_comb begin
    cmd_push  = bus.cmd_valid && bus.cmd_ready && !flush;
    rsp_pop   = bus.rsp_valid && bus.rsp_ready && !flush;
    start_ok  = (state_q == S_IDLE) && (cmd_cnt != LW'(0)) && (rsp_cnt != LW'(DEPTH))
                && !flush && !bus.spi_busy;
    cmd_pop   = start_ok;
    rsp_push  = (state_q == S_CAPTURE) && !drop_q && !flush;
    tmo_hit   = (cnt_q == CW'(BUSY_TMO - 1));
    gap_done  = (cnt_q == CW'(GAP_TICKS - 1));
    post_xfer = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start_ok) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (bus.spi_busy)  state_d = S_WAIT_DONE;
        else if (tmo_hit)  state_d = post_xfer;
      end
      S_WAIT_DONE: if (!bus.spi_busy) state_d = S_CAPTURE;
      S_CAPTURE:   state_d = post_xfer;
      S_GAP:       if (gap_done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // FSM outputs: Moore decode of the state register plus FIFO status.
  always_comb begin
    bus.spi_start   = 1'b0;
    bus.spi_tx_data = tx_q;
    bus.cmd_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_data    = '0;
    idle            = 1'b0;
    cmd_level       = cmd_cnt;
    rsp_level       = rsp_cnt;
    bus.spi_start   = (state_q == S_ISSUE);
    bus.cmd_ready   = (cmd_cnt != LW'(DEPTH));
    bus.rsp_valid   = (rsp_cnt != LW'(0));
    if (rsp_cnt != LW'(0)) bus.rsp_data = rsp_mem[rsp_rptr];
    idle            = (state_q == S_IDLE) && (cmd_cnt == LW'(0)) && !bus.spi_busy;
  end

  // Shared timeout / gap counter, restarted on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             cnt_q <= '0;
    else if (state_d != state_q)                            cnt_q <= '0;
    else if (state_q == S_WAIT_BUSY || state_q == S_GAP)    cnt_q <= cnt_q + CW'(1);
  end

  // Flush while a transfer is on the bus marks its response for discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= 1'b0;
    else if (state_q == S_ISSUE || state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) begin
      if (flush) drop_q <= 1'b1;
    end else begin
      drop_q <= 1'b0;
    end
  end

  // Sticky busy-timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                        err_tmo <= 1'b0;
    else if (flush)                                                    err_tmo <= 1'b0;
    else if (state_q == S_WAIT_BUSY && !bus.spi_busy && tmo_hit)       err_tmo <= 1'b1;
  end

  // Transmit word held from issue until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tx_q <= '0;
    else if (cmd_pop) tx_q <= cmd_mem[cmd_rptr];
  end

  // Command FIFO storage.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wptr] <= bus.cmd_data;
  end

  // Command FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wptr <= '0;
      cmd_rptr <= '0;
      cmd_cnt  <= '0;
    end else if (flush) begin
      cmd_wptr <= '0;
      cmd_rptr <= '0;
      cmd_cnt  <= '0;
    end else begin
      if (cmd_push) cmd_wptr <= cmd_wptr + AW'(1);
      if (cmd_pop)  cmd_rptr <= cmd_rptr + AW'(1);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt <= cmd_cnt + LW'(1);
        2'b01:   cmd_cnt <= cmd_cnt - LW'(1);
        default: cmd_cnt <= cmd_cnt;
      endcase
    end
  end

  // Response FIFO storage.
  always_ff @(posedge clk) begin
    if (rsp_push) rsp_mem[rsp_wptr] <= bus.spi_rx_data;
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_wptr <= '0;
      rsp_rptr <= '0;
      rsp_cnt  <= '0;
    end else if (flush) begin
      rsp_wptr <= '0;
      rsp_rptr <= '0;
      rsp_cnt  <= '0;
    end else begin
      if (rsp_push) rsp_wptr <= rsp_wptr + AW'(1);
      if (rsp_pop)  rsp_rptr <= rsp_rptr + AW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + LW'(1);
        2'b01:   rsp_cnt <= rsp_cnt - LW'(1);
        default: rsp_cnt <= rsp_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Scoreboard bench for spi_xfer_queue with a loopback spi_master model (rx word = tx word).
module tb_spi_xfer_queue;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned GAP   = 8;
  localparam int unsigned TMO   = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;
  localparam int          XFER  = 16;
  // busy high XFER cycles, then ISSUE, WAIT_DONE exit, CAPTURE, IDLE, plus the gap
  localparam int          SPACING = XFER + GAP + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [LW-1:0] cmd_level, rsp_level;
  logic idle, err_tmo;

  spi_xfer_queue_if #(.DATA_WIDTH(DW)) bus ();

  spi_xfer_queue #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP_TICKS(GAP), .BUSY_TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave),
    .cmd_level(cmd_level), .rsp_level(rsp_level), .idle(idle), .err_tmo(err_tmo)
  );

  always #4 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_starts = 0;
  int last_start_cyc = 0;
  int start_cyc [$];
  logic [DW-1:0] exp_q [$];
  bit rsp_seen = 1'b0;
  bit slave_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // spi_master loopback model: busy for XFER cycles after a start, rx = tx at busy fall.
  logic          m_busy;
  int            m_cnt;
  logic [DW-1:0] m_shadow, m_rx;
  assign bus.spi_busy    = m_busy;
  assign bus.spi_rx_data = m_rx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_cnt <= 0; m_shadow <= '0; m_rx <= '0;
    end else if (!m_busy) begin
      if (bus.spi_start && slave_en) begin
        m_busy <= 1'b1; m_cnt <= XFER; m_shadow <= bus.spi_tx_data;
      end
    end else if (m_cnt == 1) begin
      m_busy <= 1'b0; m_rx <= m_shadow;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop/compare responses, record starts, check start legality and tx stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_valid) rsp_seen = 1'b1;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", {16'h0, bus.rsp_data}, 32'hDEAD);
        else chk("rsp_data", {16'h0, bus.rsp_data}, {16'h0, exp_q.pop_front()});
      end
      if (bus.spi_start) begin
        n_starts++;
        last_start_cyc = cyc;
        start_cyc.push_back(cyc);
        if (bus.spi_busy) chk("start_while_busy", 32'd1, 32'd0);
      end
      if (m_busy && m_cnt == 1) chk("tx_stable", {16'h0, bus.spi_tx_data}, {16'h0, m_shadow});
    end
  end

  task automatic push(input logic [DW-1:0] w, input bit expect_rsp);
    int n = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = w;
    @(negedge clk);
    while (!bus.cmd_ready && n < 500) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) chk("push_accept", 32'd0, 32'd1);
    else if (expect_rsp) exp_q.push_back(w);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic pop_one();
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_busy(input logic v, input int budget, input string nm);
    int n = 0;
    @(negedge clk);
    while (bus.spi_busy !== v && n < budget) begin @(negedge clk); n++; end
    chk(nm, {31'h0, bus.spi_busy}, {31'h0, v});
  endtask

  task automatic wait_drained(input int budget, input string nm);
    int n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && idle && rsp_level == 0) && n < budget) begin
      @(negedge clk); n++;
    end
    chk(nm, {31'h0, (exp_q.size() == 0 && idle && rsp_level == 0)}, 32'd1);
  endtask

  task automatic wait_rsp_level(input logic [LW-1:0] v, input int budget, input string nm);
    int n = 0;
    @(negedge clk);
    while (rsp_level != v && n < budget) begin @(negedge clk); n++; end
    chk(nm, 32'(rsp_level), 32'(v));
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int s0, t_fall, t_valid, n;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'd1);
    chk("rst_idle", {31'h0, idle}, 32'd1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    chk("rst_spi_start", {31'h0, bus.spi_start}, 32'd0);
    chk("rst_cmd_level", 32'(cmd_level), 32'd0);
    chk("rst_rsp_level", 32'(rsp_level), 32'd0);
    chk("rst_err_tmo", {31'h0, err_tmo}, 32'd0);
    chk("rst_tx_data", {16'h0, bus.spi_tx_data}, 32'd0);
    chk("rst_rsp_data", {16'h0, bus.rsp_data}, 32'd0);

    // Single word through loopback, busy-fall to rsp_valid latency
    s0 = n_starts;
    push(16'hA5A5, 1'b1);
    wait_busy(1'b1, 20, "single_busy_rise");
    wait_busy(1'b0, 40, "single_busy_fall");
    t_fall = cyc;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
    t_valid = cyc;
    chk("rsp_latency", 32'(t_valid - t_fall), 32'd2);
    chk("single_rsp_data", {16'h0, bus.rsp_data}, 32'hA5A5);
    chk("single_start_count", 32'(n_starts - s0), 32'd1);
    pop_one();
    wait_drained(100, "single_drain");
    chk("single_cmd_level", 32'(cmd_level), 32'd0);

    // Eight words with rsp_ready low fill the rsp FIFO
    s0 = n_starts;
    for (int i = 1; i <= 8; i++) push(DW'(i), 1'b1);
    wait_rsp_level(LW'(8), 600, "fill_rsp_level");
    chk("fill_start_count", 32'(n_starts - s0), 32'd8);
    chk("fill_rsp_valid", {31'h0, bus.rsp_valid}, 32'd1);

    // Eight more commands stall behind the full rsp FIFO
    s0 = n_starts;
    for (int i = 9; i <= 16; i++) push(DW'(i), 1'b1);
    @(negedge clk);
    chk("stall_cmd_level", 32'(cmd_level), 32'd8);
    chk("stall_cmd_ready", {31'h0, bus.cmd_ready}, 32'd0);
    idle_cycles(40);
    chk("stall_no_start", 32'(n_starts - s0), 32'd0);

    // One pop releases exactly one issue
    pop_one();
    idle_cycles(50);
    chk("one_pop_one_start", 32'(n_starts - s0), 32'd1);
    chk("one_pop_rsp_level", 32'(rsp_level), 32'd8);
    chk("one_pop_cmd_level", 32'(cmd_level), 32'd7);

    // Drain remaining responses in order
    bus.rsp_ready = 1'b1;
    wait_drained(1200, "drain_all");
    chk("drain_start_count", 32'(n_starts - s0), 32'd8);

    // Start-to-start spacing for four consecutive words
    start_cyc.delete();
    for (int i = 0; i < 4; i++) push(DW'(16'h5A00 + i), 1'b1);
    wait_drained(600, "spacing_drain");
    chk("spacing_count", 32'(start_cyc.size()), 32'd4);
    if (start_cyc.size() == 4)
      for (int i = 0; i < 3; i++) chk("start_spacing", 32'(start_cyc[i+1] - start_cyc[i]), 32'(SPACING));

    // No slave: busy never rises
    slave_en = 1'b0;
    push(16'h1111, 1'b0);
    n = 0;
    @(negedge clk);
    while (!err_tmo && n < 40) begin @(negedge clk); n++; end
    chk("tmo_err_set", {31'h0, err_tmo}, 32'd1);
    chk("tmo_latency", 32'(cyc - last_start_cyc), 32'(TMO + 1));
    chk("tmo_no_rsp", 32'(rsp_level), 32'd0);
    slave_en = 1'b1;
    s0 = n_starts;
    push(16'h2222, 1'b1);
    wait_drained(200, "tmo_next_drain");
    chk("tmo_next_issued", 32'(n_starts - s0), 32'd1);
    chk("tmo_sticky", {31'h0, err_tmo}, 32'd1);

    // Flush during WAIT_DONE with three words still queued
    for (int i = 0; i < 4; i++) push(DW'(16'h0B01 + i), 1'b1);
    wait_busy(1'b1, 40, "flush_busy_rise");
    @(posedge clk); #1 flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 flush = 1'b0;
    s0 = n_starts;
    rsp_seen = 1'b0;
    @(negedge clk);
    chk("flush_cmd_level", 32'(cmd_level), 32'd0);
    chk("flush_rsp_level", 32'(rsp_level), 32'd0);
    chk("flush_err_clear", {31'h0, err_tmo}, 32'd0);
    wait_busy(1'b0, 40, "flush_bus_completes");
    idle_cycles(30);
    chk("flush_no_rsp", {31'h0, rsp_seen}, 32'd0);
    chk("flush_idle", {31'h0, idle}, 32'd1);
    chk("flush_no_new_start", 32'(n_starts - s0), 32'd0);
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
